// File: rtl/rll_key_loader_if.sv
// Serial key-load link between the key store (master) and rll_key_loader (slave).
// Carries the frame handshake inputs and the registered key/status outputs.
interface rll_key_loader_if #(
  parameter int KEY_WIDTH = 16,
  parameter int MAX_FAIL  = 3
);
  logic                              start;
  logic                              sdi;
  logic                              sdi_vld;
  logic [KEY_WIDTH-1:0]              key_out;
  logic                              key_valid;
  logic                              busy;
  logic                              par_err;
  logic                              lockout;
  logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt;

  modport master (
    output start, sdi, sdi_vld,
    input  key_out, key_valid, busy, par_err, lockout, fail_cnt
  );

  modport slave (
    input  start, sdi, sdi_vld,
    output key_out, key_valid, busy, par_err, lockout, fail_cnt
  );
endinterface

// File: rtl/rll_key_loader.sv
// Parity-checked serial key loader for rll16 locked netlists; drives a decoy key until a good key commits.
// Optional macro RLL_KEY_ZEROIZE_EN adds a zeroize input that wipes the committed key.
module rll_key_loader #(
  parameter int                  KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = 16'h0000,
  parameter bit                  PAR_ODD   = 1'b0,
  parameter int                  MAX_FAIL  = 3
) (
  input  logic clk,
  input  logic rst_n,
`ifdef RLL_KEY_ZEROIZE_EN
  input  logic zeroize,
`endif
  rll_key_loader_if.slave bus
);

  localparam int BW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam int CW = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PARITY  = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  state_e               state_q;
  logic [BW-1:0]        cnt_q;
  logic [KEY_WIDTH-1:0] shadow_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 key_valid_q;
  logic                 busy_q;
  logic                 par_err_q;
  logic                 lockout_q;
  logic [CW-1:0]        fail_cnt_q;

  logic parity_ok;
  logic zeroize_req;

  assign parity_ok = ((^shadow_q) ^ bus.sdi) == PAR_ODD;

`ifdef RLL_KEY_ZEROIZE_EN
  assign zeroize_req = zeroize && (state_q != LOCKOUT);
`else
  assign zeroize_req = 1'b0;
`endif

  // The committed key (key_q) only changes on a passing parity check, so a reload never exposes a partial key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      key_q       <= DECOY_KEY;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      par_err_q   <= 1'b0;
      lockout_q   <= 1'b0;
      fail_cnt_q  <= '0;
    end else if (zeroize_req) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      key_q       <= DECOY_KEY;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= SHIFT;
            cnt_q     <= '0;
            shadow_q  <= '0;
            busy_q    <= 1'b1;
            par_err_q <= 1'b0;
          end
        end

        SHIFT: begin
          if (bus.start) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            par_err_q <= 1'b0;
          end else if (bus.sdi_vld) begin
            shadow_q[cnt_q] <= bus.sdi;
            cnt_q           <= cnt_q + 1'b1;
            if (cnt_q == BW'(KEY_WIDTH - 1)) begin
              state_q <= PARITY;
            end
          end
        end

        PARITY: begin
          if (bus.start) begin
            state_q   <= SHIFT;
            cnt_q     <= '0;
            shadow_q  <= '0;
            par_err_q <= 1'b0;
          end else if (bus.sdi_vld) begin
            busy_q <= 1'b0;
            if (parity_ok) begin
              key_q       <= shadow_q;
              key_valid_q <= 1'b1;
              fail_cnt_q  <= '0;
              state_q     <= IDLE;
            end else begin
              par_err_q <= 1'b1;
              if (fail_cnt_q != CW'(MAX_FAIL)) begin
                fail_cnt_q <= fail_cnt_q + 1'b1;
              end
              // Reaching the failure limit drops the key and parks here until reset.
              if (fail_cnt_q + 1'b1 >= CW'(MAX_FAIL)) begin
                state_q     <= LOCKOUT;
                key_q       <= DECOY_KEY;
                key_valid_q <= 1'b0;
                lockout_q   <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end

        LOCKOUT: begin
          key_q       <= DECOY_KEY;
          key_valid_q <= 1'b0;
          lockout_q   <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_out   = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.busy      = busy_q;
  assign bus.par_err   = par_err_q;
  assign bus.lockout   = lockout_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed testbench for rll_key_loader with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rll_key_loader;

  logic clk;
  logic rst_n;
`ifdef RLL_KEY_ZEROIZE_EN
  logic zeroize;
`endif

  int checks;
  int errors;

  rll_key_loader_if #(.KEY_WIDTH(16), .MAX_FAIL(3)) bus ();

  rll_key_loader #(
    .KEY_WIDTH(16),
    .DECOY_KEY(16'h0000),
    .PAR_ODD  (1'b0),
    .MAX_FAIL (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef RLL_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    bus.sdi     = b;
    bus.sdi_vld = 1'b1;
    @(negedge clk);
    bus.sdi_vld = 1'b0;
    bus.sdi     = 1'b0;
  endtask

  task automatic drive_bits(input logic [15:0] key, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(key[i]);
  endtask

  task automatic drive_frame(input logic [15:0] key, input logic p);
    drive_start();
    drive_bits(key, 16);
    drive_bit(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.sdi     = 1'b1;
    bus.sdi_vld = 1'b0;
    rst_n       = 1'b0;
    idle(3);
    checks++;
    if (bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.lockout !== 1'b0 || bus.par_err !== 1'b0 || bus.fail_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: key=%h vld=%b busy=%b lock=%b perr=%b fcnt=%0d, need 0000/0/0/0/0/0",
               bus.key_out, bus.key_valid, bus.busy, bus.lockout, bus.par_err, bus.fail_cnt);
    end
    rst_n = 1'b1;
    // sdi_vld activity without start must be ignored in IDLE
    bus.sdi_vld = 1'b1;
    idle(20);
    bus.sdi_vld = 1'b0;
    bus.sdi     = 1'b0;
    checks++;
    if (bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0 || bus.busy !== 1'b0 || bus.lockout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: key=%h vld=%b busy=%b lock=%b, need 0000/0/0/0",
               bus.key_out, bus.key_valid, bus.busy, bus.lockout);
    end
  endtask

  task automatic test_good_load();
    drive_start();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_on_start: got %b need 1", bus.busy);
    end
    drive_bits(16'hA5C3, 16);
    checks++;
    if (bus.key_valid !== 1'b0 || bus.key_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL pre_parity: key=%h vld=%b need 0000/0", bus.key_out, bus.key_valid);
    end
    drive_bit(1'b0);
    checks++;
    if (bus.key_out !== 16'hA5C3 || bus.key_valid !== 1'b1 || bus.fail_cnt !== 2'd0 ||
        bus.busy !== 1'b0 || bus.par_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL good_load: key=%h vld=%b fcnt=%0d busy=%b perr=%b need a5c3/1/0/0/0",
               bus.key_out, bus.key_valid, bus.fail_cnt, bus.busy, bus.par_err);
    end
  endtask

  task automatic test_bad_parity();
    drive_start();
    drive_bits(16'h1234, 10);
    checks++;
    if (bus.key_out !== 16'hA5C3 || bus.key_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_hold: key=%h vld=%b busy=%b need a5c3/1/1",
               bus.key_out, bus.key_valid, bus.busy);
    end
    drive_bits(16'h1234 >> 10, 6);
    drive_bit(1'b0);
    checks++;
    if (bus.par_err !== 1'b1 || bus.fail_cnt !== 2'd1 || bus.key_out !== 16'hA5C3 ||
        bus.key_valid !== 1'b1 || bus.busy !== 1'b0 || bus.lockout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_parity: perr=%b fcnt=%0d key=%h vld=%b busy=%b lock=%b need 1/1/a5c3/1/0/0",
               bus.par_err, bus.fail_cnt, bus.key_out, bus.key_valid, bus.busy, bus.lockout);
    end
  endtask

  task automatic test_lockout();
    drive_frame(16'h1234, 1'b0);
    checks++;
    if (bus.fail_cnt !== 2'd2 || bus.lockout !== 1'b0 || bus.key_out !== 16'hA5C3 || bus.key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL second_fail: fcnt=%0d lock=%b key=%h vld=%b need 2/0/a5c3/1",
               bus.fail_cnt, bus.lockout, bus.key_out, bus.key_valid);
    end
    // A5C3 has eight ones, so p=1 is a parity failure
    drive_frame(16'hA5C3, 1'b1);
    checks++;
    if (bus.lockout !== 1'b1 || bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0 ||
        bus.fail_cnt !== 2'd3 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lockout_entry: lock=%b key=%h vld=%b fcnt=%0d busy=%b need 1/0000/0/3/0",
               bus.lockout, bus.key_out, bus.key_valid, bus.fail_cnt, bus.busy);
    end
    drive_start();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lockout_start_ignored: busy=%b need 0", bus.busy);
    end
    drive_bits(16'hA5C3, 16);
    drive_bit(1'b0);
    idle(2);
    checks++;
    if (bus.lockout !== 1'b1 || bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0 || bus.fail_cnt !== 2'd3) begin
      errors++;
      $display("[TB] FAIL lockout_sticky: lock=%b key=%h vld=%b fcnt=%0d need 1/0000/0/3",
               bus.lockout, bus.key_out, bus.key_valid, bus.fail_cnt);
    end
    do_reset();
    checks++;
    if (bus.lockout !== 1'b0 || bus.fail_cnt !== 2'd0 || bus.par_err !== 1'b0 ||
        bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lockout_reset: lock=%b fcnt=%0d perr=%b key=%h vld=%b need 0/0/0/0000/0",
               bus.lockout, bus.fail_cnt, bus.par_err, bus.key_out, bus.key_valid);
    end
  endtask

  task automatic test_stall_restart();
    drive_frame(16'h1234, 1'b0);
    drive_start();
    drive_bits(16'h0055, 8);
    idle(10);
    checks++;
    if (bus.busy !== 1'b1 || bus.key_valid !== 1'b0 || bus.par_err !== 1'b0 || bus.fail_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL stall_hold: busy=%b vld=%b perr=%b fcnt=%0d need 1/0/0/1",
               bus.busy, bus.key_valid, bus.par_err, bus.fail_cnt);
    end
    drive_start();
    drive_bits(16'hFFFF, 16);
    drive_bit(1'b0);
    checks++;
    if (bus.key_out !== 16'hFFFF || bus.key_valid !== 1'b1 || bus.fail_cnt !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_ffff: key=%h vld=%b fcnt=%0d busy=%b need ffff/1/0/0",
               bus.key_out, bus.key_valid, bus.fail_cnt, bus.busy);
    end
    // Aborted ones must not leak into an all-zero key loaded after a restart
    drive_start();
    drive_bits(16'hFFFF, 8);
    drive_start();
    drive_bits(16'h0000, 16);
    drive_bit(1'b0);
    checks++;
    if (bus.key_out !== 16'h0000 || bus.key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_clears_shadow: key=%h vld=%b need 0000/1", bus.key_out, bus.key_valid);
    end
    // start during the parity phase restarts the frame instead of checking
    drive_start();
    drive_bits(16'h00FF, 16);
    drive_start();
    drive_bits(16'h0F0F, 16);
    drive_bit(1'b0);
    checks++;
    if (bus.key_out !== 16'h0F0F || bus.key_valid !== 1'b1 || bus.par_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_in_parity: key=%h vld=%b perr=%b need 0f0f/1/0",
               bus.key_out, bus.key_valid, bus.par_err);
    end
  endtask

  task automatic test_mid_frame_reset();
    drive_start();
    drive_bits(16'hFFFF, 5);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: busy=%b key=%h vld=%b need 0/0000/0",
               bus.busy, bus.key_out, bus.key_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_frame(16'h8001, 1'b0);
    checks++;
    if (bus.key_out !== 16'h8001 || bus.key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_after_reset: key=%h vld=%b need 8001/1", bus.key_out, bus.key_valid);
    end
  endtask

`ifdef RLL_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    drive_frame(16'hA5C3, 1'b0);
    drive_frame(16'h1234, 1'b0);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    checks++;
    if (bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0 || bus.fail_cnt !== 2'd1 ||
        bus.par_err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zeroize: key=%h vld=%b fcnt=%0d perr=%b busy=%b need 0000/0/1/1/0",
               bus.key_out, bus.key_valid, bus.fail_cnt, bus.par_err, bus.busy);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.sdi     = 1'b0;
    bus.sdi_vld = 1'b0;
`ifdef RLL_KEY_ZEROIZE_EN
    zeroize     = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_parity();
    test_lockout();
    test_stall_restart();
    test_mid_frame_reset();
`ifdef RLL_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
